imm_field_encoder: RTL

- Inverse of the CPU's immediate sign-extension stage.
- Accepts a 64-bit immediate value and a format code, range-checks the value, and packs it into the 26-bit instruction field (In26) at the bit positions the decode stage extracts from.
- For MOVZ, searches the halfword positions sequentially to produce the lsl amount.
- Feeds the instruction-memory image builder and the self-test instruction generator; valid/ready handshake on both sides.

---
 rtl/imm_field_encoder_pkg.sv | 50 +++++
 rtl/imm_field_encoder_if.sv | 29 ++
 rtl/imm_field_encoder_range_check.sv | 36 +++
 rtl/imm_field_encoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/imm_field_encoder_pkg.sv
// -----------------------------------------------------------------------------
// imm_field_encoder_pkg
// Shared definitions for the immediate field encoder: format codes, the
// width/offset of each immediate field inside the 26-bit In26 instruction
// field, the FSM state encoding and a helper that packs a field.
// No ports (package).
// -----------------------------------------------------------------------------
package imm_field_encoder_pkg;

  // Format code is {movz, Ctrl}
  localparam logic [2:0] FMT_I    = 3'b000;
  localparam logic [2:0] FMT_D    = 3'b001;
  localparam logic [2:0] FMT_B    = 3'b010;
  localparam logic [2:0] FMT_CBZ  = 3'b011;
  localparam logic [2:0] FMT_MOVZ = 3'b100;

  localparam int unsigned FIELD_W  = 26;

  // Field width / bit offset inside In26 for every format
  localparam int unsigned I_W      = 12;
  localparam int unsigned I_OFF    = 10;
  localparam int unsigned D_W      = 9;
  localparam int unsigned D_OFF    = 12;
  localparam int unsigned B_W      = 26;
  localparam int unsigned B_OFF    = 0;
  localparam int unsigned CBZ_W    = 19;
  localparam int unsigned CBZ_OFF  = 5;
  localparam int unsigned MOVZ_W   = 16;
  localparam int unsigned MOVZ_OFF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CHECK = 2'b01,
    ST_SCAN  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Keep the low 'width' bits of value and place them at 'offset' in In26.
  // Bits outside the field are always zero.
  function automatic logic [25:0] pack_field(input logic [63:0] value,
                                             input int unsigned width,
                                             input int unsigned offset);
    logic [63:0] mask;
    logic [63:0] shifted;
    mask    = (64'd1 << width) - 64'd1;
    shifted = (value & mask) << offset;
    return shifted[25:0];
  endfunction

endpackage

// File: rtl/imm_field_encoder_if.sv
// -----------------------------------------------------------------------------
// imm_field_encoder_if
// Request/response bundle of the immediate field encoder.
//   request : in_valid, in_ready, Imm[63:0], Ctrl[1:0], movz
//   response: out_valid, out_ready, In26[25:0], lsl[1:0], err
// master = producer of requests / consumer of results, slave = the encoder.
// -----------------------------------------------------------------------------
interface imm_field_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] Imm;
  logic [1:0]  Ctrl;
  logic        movz;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] In26;
  logic [1:0]  lsl;
  logic        err;

  modport master (
    output in_valid, Imm, Ctrl, movz, out_ready,
    input  in_ready, out_valid, In26, lsl, err
  );

  modport slave (
    input  in_valid, Imm, Ctrl, movz, out_ready,
    output in_ready, out_valid, In26, lsl, err
  );
endinterface

// File: rtl/imm_field_encoder_range_check.sv
// -----------------------------------------------------------------------------
// imm_range_check
// Combinational range check: does a 64-bit value fit in N bits?
//   SIGNED=0 : value[63:N] must be all zero.
//   SIGNED=1 : value[63:N-1] must all equal the sign bit value[N-1].
// Ports:
//   i_value [63:0]  value under test
//   o_fits          1 when the value is representable
// -----------------------------------------------------------------------------
module imm_range_check #(
  parameter int unsigned N      = 12,
  parameter bit          SIGNED = 1'b0
) (
  input  logic [63:0] i_value,
  output logic        o_fits
);

  // For signed checks the sign bit itself joins the "must be uniform" group
  localparam int unsigned LO = SIGNED ? (N - 1) : N;

  logic [63-LO:0] w_upper;
  logic           w_unused_low;

  assign w_upper      = i_value[63:LO];
  assign w_unused_low = ^i_value[LO-1:0];

  // Uniform upper bits (signed) or all-zero upper bits (unsigned)
  always_comb begin
    if (SIGNED) begin
      o_fits = (&w_upper) | ~(|w_upper);
    end else begin
      o_fits = ~(|w_upper);
    end
  end

endmodule

// File: rtl/imm_field_encoder.sv
// -----------------------------------------------------------------------------
// imm_field_encoder
// Inverse of the immediate sign-extension stage: range-checks a 64-bit
// immediate for the selected format and packs it into the 26-bit In26 field.
// MOVZ searches halfword positions one per cycle to find the lsl amount.
// Ports:
//   CLK    rising-edge clock
//   Reset  synchronous, active-high
//   bus    imm_field_encoder_if.slave (in_valid/in_ready, Imm, Ctrl, movz,
//          out_valid/out_ready, In26, lsl, err)
// Parameter:
//   ERR_ZERO_FIELD  1: In26 forced to 0 on err; 0: truncated bits still packed
// -----------------------------------------------------------------------------
module imm_field_encoder
  import imm_field_encoder_pkg::*;
#(
  parameter bit ERR_ZERO_FIELD = 1'b1
) (
  input  logic                CLK,
  input  logic                Reset,
  imm_field_encoder_if.slave  bus
);

  state_t      r_state;
  logic [63:0] r_imm;
  logic [2:0]  r_fmt;
  logic [1:0]  r_k;
  logic [25:0] r_in26;
  logic [1:0]  r_lsl;
  logic        r_err;
  logic        r_in_ready;
  logic        r_out_valid;

  logic        w_accept;
  logic [2:0]  w_fmt_in;
  logic        w_fits_i;
  logic        w_fits_d;
  logic        w_fits_b;
  logic        w_fits_cbz;
  logic        w_fix_known;
  logic        w_fix_fits;
  logic [25:0] w_fix_field;
  logic [5:0]  w_hw_shift;
  logic [63:0] w_other_mask;
  logic        w_hw_match;
  logic [15:0] w_hw;
  logic [25:0] w_movz_field;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_fmt_in = {bus.movz, bus.Ctrl};

  imm_range_check #(.N(I_W),   .SIGNED(1'b0)) u_rc_i   (.i_value(r_imm), .o_fits(w_fits_i));
  imm_range_check #(.N(D_W),   .SIGNED(1'b1)) u_rc_d   (.i_value(r_imm), .o_fits(w_fits_d));
  imm_range_check #(.N(B_W),   .SIGNED(1'b1)) u_rc_b   (.i_value(r_imm), .o_fits(w_fits_b));
  imm_range_check #(.N(CBZ_W), .SIGNED(1'b1)) u_rc_cbz (.i_value(r_imm), .o_fits(w_fits_cbz));

  // Legality and packed field for the single-cycle formats
  always_comb begin
    w_fix_known = 1'b0;
    w_fix_fits  = 1'b0;
    w_fix_field = 26'd0;
    case (r_fmt)
      FMT_I: begin
        w_fix_known = 1'b1;
        w_fix_fits  = w_fits_i;
        w_fix_field = pack_field(r_imm, I_W, I_OFF);
      end
      FMT_D: begin
        w_fix_known = 1'b1;
        w_fix_fits  = w_fits_d;
        w_fix_field = pack_field(r_imm, D_W, D_OFF);
      end
      FMT_B: begin
        w_fix_known = 1'b1;
        w_fix_fits  = w_fits_b;
        w_fix_field = pack_field(r_imm, B_W, B_OFF);
      end
      FMT_CBZ: begin
        w_fix_known = 1'b1;
        w_fix_fits  = w_fits_cbz;
        w_fix_field = pack_field(r_imm, CBZ_W, CBZ_OFF);
      end
      default: begin
        w_fix_known = 1'b0;
        w_fix_fits  = 1'b0;
        w_fix_field = 26'd0;
      end
    endcase
  end

  // MOVZ: halfword k matches when every other halfword is zero
  assign w_hw_shift   = {r_k, 4'b0000};
  assign w_other_mask = ~(64'h0000_0000_0000_FFFF << w_hw_shift);
  assign w_hw_match   = ((r_imm & w_other_mask) == 64'd0);
  assign w_hw         = r_imm[w_hw_shift +: 16];
  assign w_movz_field = pack_field({48'd0, w_hw}, MOVZ_W, MOVZ_OFF);

  // Control FSM with registered result and handshake outputs
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_imm       <= 64'd0;
      r_fmt       <= 3'd0;
      r_k         <= 2'd0;
      r_in26      <= 26'd0;
      r_lsl       <= 2'd0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_imm      <= bus.Imm;
            r_fmt      <= w_fmt_in;
            r_k        <= 2'd0;
            r_in_ready <= 1'b0;
            r_state    <= (w_fmt_in == FMT_MOVZ) ? ST_SCAN : ST_CHECK;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          r_lsl <= 2'd0;
          r_err <= ~w_fix_fits;
          if (w_fix_fits) begin
            r_in26 <= w_fix_field;
          end else if (!ERR_ZERO_FIELD && w_fix_known) begin
            // Out-of-range value still packed (truncated) when not zeroing
            r_in26 <= w_fix_field;
          end else begin
            r_in26 <= 26'd0;
          end
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_SCAN: begin
          if (w_hw_match) begin
            r_in26      <= w_movz_field;
            r_lsl       <= r_k;
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else if (r_k == 2'd3) begin
            r_in26      <= ERR_ZERO_FIELD ? 26'd0 : pack_field(r_imm, MOVZ_W, MOVZ_OFF);
            r_lsl       <= 2'd0;
            r_err       <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_k <= r_k + 2'd1;
          end
        end
        ST_DONE: begin
          // Result held until the consumer takes it
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.In26      = r_in26;
  assign bus.lsl       = r_lsl;
  assign bus.err       = r_err;

endmodule
